// File: rtl/smi_arbiter.sv
// Two-port round-robin arbiter in front of an SMI (MDIO) engine: latches one request,
// issues a single command pulse, waits for completion or timeout, then acks the requester.
module smi_arbiter #(
    parameter logic [31:0] TIMEOUT = 32'd200000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [4:0]  req0_phy_addr,
    input  logic [4:0]  req0_reg_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ack,
    output logic        req0_err,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [4:0]  req1_phy_addr,
    input  logic [4:0]  req1_reg_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ack,
    output logic        req1_err,

    output logic [15:0] rsp_rdata,

    output logic        smi_read_req,
    output logic        smi_write_req,
    output logic [4:0]  smi_phy_addr,
    output logic [4:0]  smi_reg_addr,
    output logic [15:0] smi_write_data,
    input  logic [15:0] smi_read_data,
    input  logic        smi_data_valid,
    input  logic        smi_done,

    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state;
    logic        rr;
    logic        grant;
    logic        pick;
    logic        timed_out;
    logic        timeout_hit;
    logic        cmd_write;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic [31:0] timer;

    // With both ports asking, the round-robin pointer decides; otherwise whoever asks wins.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid)
            pick = rr;
        else if (req1_valid)
            pick = 1'b1;
    end

    assign timeout_hit = (timer == TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr        <= 1'b0;
            grant     <= 1'b0;
            timed_out <= 1'b0;
            cmd_write <= 1'b0;
            cmd_phy   <= 5'd0;
            cmd_reg   <= 5'd0;
            cmd_wdata <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant     <= pick;
                        timed_out <= 1'b0;
                        cmd_write <= pick ? req1_write    : req0_write;
                        cmd_phy   <= pick ? req1_phy_addr : req0_phy_addr;
                        cmd_reg   <= pick ? req1_reg_addr : req0_reg_addr;
                        cmd_wdata <= pick ? req1_wdata    : req0_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (smi_done) begin
                        state     <= S_RESP;
                        rr        <= ~grant;
                        timed_out <= 1'b0;
                    end else if (timeout_hit) begin
                        state     <= S_RESP;
                        rr        <= ~grant;
                        timed_out <= 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= 32'd0;
        else if (state == S_WAIT)
            timer <= timer + 32'd1;
        else
            timer <= 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_rdata <= 16'd0;
        else if (state == S_WAIT && smi_data_valid && !cmd_write)
            rsp_rdata <= smi_read_data;
    end

    assign busy           = (state != S_IDLE);
    assign smi_read_req   = (state == S_ISSUE) && !cmd_write;
    assign smi_write_req  = (state == S_ISSUE) && cmd_write;
    assign smi_phy_addr   = cmd_phy;
    assign smi_reg_addr   = cmd_reg;
    assign smi_write_data = cmd_wdata;
    assign req0_ack       = (state == S_RESP) && !grant;
    assign req1_ack       = (state == S_RESP) && grant;
    assign req0_err       = req0_ack && timed_out;
    assign req1_err       = req1_ack && timed_out;

endmodule
